// File: rtl/decoder_3to8.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : decoder_3to8
// Description : Registered 3-to-8 one-hot decoder with enable and selectable
//               output polarity. Y updates one clock after I/en are sampled.
//               valid marks that Y holds a real decode, not the reset value.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module decoder_3to8 #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] I,
  output logic [7:0] Y,
  output logic       valid
);

  // Pattern driven while no decode has been loaded (all lines inactive).
  localparam logic [7:0] INACTIVE = ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [7:0] onehot;
  logic [7:0] decoded;

  // Each output line compares the select against its own index.
  generate
    for (genvar k = 0; k < 8; k++) begin : g_line
      assign onehot[k] = (I == 3'(k));
    end
  endgenerate

  // Apply output polarity before the register so Y is a clean flop output.
  always_comb begin
    decoded = onehot;
    if (ACTIVE_LOW) begin
      decoded = ~onehot;
    end
  end

  // Output register: reset dominates enable; en=0 holds the last decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      Y     <= INACTIVE;
      valid <= 1'b0;
    end else if (en) begin
      Y     <= decoded;
      valid <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_decoder_3to8.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_decoder_3to8
// Description : Directed and random self-checking bench for decoder_3to8,
//               driving an active-high and an active-low instance in parallel.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_decoder_3to8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [2:0] I   = 3'd0;
  logic [7:0] y_hi;
  logic       valid_hi;
  logic [7:0] y_lo;
  logic       valid_lo;

  int checks   = 0;
  int failures = 0;

  // Hand-written decode table for the active-high polarity.
  logic [7:0] tbl [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  decoder_3to8 #(.ACTIVE_LOW(1'b0)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .I    (I),
    .Y    (y_hi),
    .valid(valid_hi)
  );

  decoder_3to8 #(.ACTIVE_LOW(1'b1)) dut_al (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .I    (I),
    .Y    (y_lo),
    .valid(valid_lo)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; I = 3'b101;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (y_hi !== 8'h00) begin
        failures++;
        $display("FAIL reset_y cycle=%0d got=%h exp=00", c, y_hi);
      end
      checks++;
      if (valid_hi !== 1'b0) begin
        failures++;
        $display("FAIL reset_valid cycle=%0d got=%b exp=0", c, valid_hi);
      end
      checks++;
      if (y_lo !== 8'hFF) begin
        failures++;
        $display("FAIL reset_y_al cycle=%0d got=%h exp=ff", c, y_lo);
      end
    end
  endtask

  task automatic test_sweep();
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      I = 3'(i);
      step();
      checks++;
      if (y_hi !== tbl[i]) begin
        failures++;
        $display("FAIL sweep_y I=%0d got=%h exp=%h", i, y_hi, tbl[i]);
      end
      checks++;
      if (valid_hi !== 1'b1) begin
        failures++;
        $display("FAIL sweep_valid I=%0d got=%b exp=1", i, valid_hi);
      end
      checks++;
      if (y_lo !== ~tbl[i]) begin
        failures++;
        $display("FAIL sweep_y_al I=%0d got=%h exp=%h", i, y_lo, ~tbl[i]);
      end
    end
  endtask

  task automatic test_hold();
    rst = 1'b0; en = 1'b1; I = 3'b011;
    step();
    checks++;
    if (y_hi !== 8'h08) begin
      failures++;
      $display("FAIL hold_load got=%h exp=08", y_hi);
    end
    en = 1'b0; I = 3'b110;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (y_hi !== 8'h08 || valid_hi !== 1'b1) begin
        failures++;
        $display("FAIL hold_keep cycle=%0d got=%h/%b exp=08/1", c, y_hi, valid_hi);
      end
      checks++;
      if (y_lo !== 8'hF7) begin
        failures++;
        $display("FAIL hold_keep_al cycle=%0d got=%h exp=f7", c, y_lo);
      end
    end
    en = 1'b1;
    step();
    checks++;
    if (y_hi !== 8'h40) begin
      failures++;
      $display("FAIL hold_release got=%h exp=40", y_hi);
    end
  endtask

  task automatic test_reset_priority();
    rst = 1'b0; en = 1'b1; I = 3'b111;
    step();
    checks++;
    if (y_hi !== 8'h80) begin
      failures++;
      $display("FAIL prio_setup got=%h exp=80", y_hi);
    end
    rst = 1'b1; en = 1'b1; I = 3'b010;
    step();
    checks++;
    if (y_hi !== 8'h00 || valid_hi !== 1'b0) begin
      failures++;
      $display("FAIL prio_reset got=%h/%b exp=00/0", y_hi, valid_hi);
    end
    rst = 1'b0;
    step();
    checks++;
    if (y_hi !== 8'h04 || valid_hi !== 1'b1) begin
      failures++;
      $display("FAIL prio_after got=%h/%b exp=04/1", y_hi, valid_hi);
    end
  endtask

  task automatic test_active_low();
    rst = 1'b1; en = 1'b1; I = 3'b000;
    step();
    checks++;
    if (y_lo !== 8'hFF || valid_lo !== 1'b0) begin
      failures++;
      $display("FAIL al_reset got=%h/%b exp=ff/0", y_lo, valid_lo);
    end
    rst = 1'b0; I = 3'b000;
    step();
    checks++;
    if (y_lo !== 8'hFE || valid_lo !== 1'b1) begin
      failures++;
      $display("FAIL al_code0 got=%h/%b exp=fe/1", y_lo, valid_lo);
    end
    I = 3'b111;
    step();
    checks++;
    if (y_lo !== 8'h7F) begin
      failures++;
      $display("FAIL al_code7 got=%h exp=7f", y_lo);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_y;
    logic       exp_v;
    rst = 1'b1; en = 1'b0;
    step();
    exp_y = 8'h00;
    exp_v = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      rst = ($urandom_range(0, 31) == 0);
      en  = 1'($urandom_range(0, 1));
      I   = 3'($urandom_range(0, 7));
      if (rst) begin
        exp_y = 8'h00;
        exp_v = 1'b0;
      end else if (en) begin
        exp_y = tbl[I];
        exp_v = 1'b1;
      end
      step();
      checks++;
      if (y_hi !== exp_y || valid_hi !== exp_v || y_lo !== ~exp_y || valid_lo !== exp_v) begin
        failures++;
        $display("FAIL random cycle=%0d got=%h/%b al=%h/%b exp=%h/%b al=%h",
                 c, y_hi, valid_hi, y_lo, valid_lo, exp_y, exp_v, ~exp_y);
      end
      if (valid_hi) begin
        checks++;
        if ($countones(y_hi) != 1 || $countones(~y_lo) != 1) begin
          failures++;
          $display("FAIL onehot cycle=%0d got=%h al=%h exp=one_active_bit", c, y_hi, y_lo);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_hold();
    test_reset_priority();
    test_active_low();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
